// File: rtl/ysyx_24120009_dmem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
package ysyx_24120009_dmem_resp_pkg;

    // Latency counter width and the legal LATENCY window it supports
    localparam int unsigned DMEM_CNT_W   = 4;
    localparam int unsigned DMEM_LAT_MIN = 1;
    localparam int unsigned DMEM_LAT_MAX = 15;

    // Responder FSM encodings
    localparam logic [1:0] DMEM_ST_IDLE = 2'd0;
    localparam logic [1:0] DMEM_ST_WAIT = 2'd1;
    localparam logic [1:0] DMEM_ST_RESP = 2'd2;

    // Request attributes captured on accept and replayed into the response
    typedef struct packed {
        logic wen;
        logic err;
    } dmem_req_flags_t;

endpackage

// File: rtl/ysyx_24120009_dmem_array.sv
// Byte-masked word array: synchronous write, registered read, contents not reset.
module ysyx_24120009_dmem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic [DEPTH_LOG2-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned MASK_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Lane-masked write and read-data capture; read word holds until the next read
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (wmask_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_24120009_dmem_resp.sv
// Data-memory responder: one request at a time, fixed latency, valid/ready response.
`ifndef ysyx_24120009_DATA_WIDTH
`define ysyx_24120009_DATA_WIDTH 32
`endif

module ysyx_24120009_dmem_resp
    import ysyx_24120009_dmem_resp_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = `ysyx_24120009_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
    parameter int unsigned           LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned LAT_W = DMEM_CNT_W;

    // Reject configurations the counter or lane logic cannot represent
    if ((LATENCY < DMEM_LAT_MIN) || (LATENCY > DMEM_LAT_MAX)) begin : g_bad_latency
        $error("ysyx_24120009_dmem_resp: LATENCY must be within 1..15");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("ysyx_24120009_dmem_resp: DATA_WIDTH must be a multiple of 8");
    end

    logic [1:0]            state_q,     state_d;
    logic [LAT_W-1:0]      cnt_q,       cnt_d;
    dmem_req_flags_t       flags_q,     flags_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic [ADDR_WIDTH-1:0] offset_c;
    logic                  in_range_c;
    logic [DEPTH_LOG2-1:0] widx_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // Address decode: unsigned offset from base, so addresses below base fall out of range
    assign offset_c   = req_addr - BASE_ADDR;
    assign in_range_c = (offset_c >> (DEPTH_LOG2 + 2)) == '0;
    assign widx_c     = offset_c[DEPTH_LOG2+1:2];
    assign accept_c   = req_valid && req_ready_q && !rst;

    ysyx_24120009_dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (accept_c && req_wen && in_range_c),
        .re_i    (accept_c && !req_wen && in_range_c),
        .addr_i  (widx_c),
        .wmask_i (req_wmask),
        .wdata_i (req_wdata),
        .rdata_o (arr_rdata)
    );

    // Next-state and response logic; WAIT counts down LATENCY-1 cycles before RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            DMEM_ST_IDLE: begin
                req_ready_d = 1'b1;
                if (accept_c) begin
                    state_d     = DMEM_ST_WAIT;
                    cnt_d       = LAT_W'(LATENCY - 1);
                    flags_d.wen = req_wen;
                    flags_d.err = !in_range_c;
                    req_ready_d = 1'b0;
                end
            end
            DMEM_ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = DMEM_ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = flags_q.err;
                    rsp_rdata_d = (flags_q.err || flags_q.wen) ? '0 : arr_rdata;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            DMEM_ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = DMEM_ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = DMEM_ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DMEM_ST_IDLE;
            cnt_q       <= '0;
            flags_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_24120009_dmem_resp.sv
// Bench for the data-memory responder: LATENCY=1 and LATENCY=4 instances share one stimulus port.
module tb_ysyx_24120009_dmem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_ready;
    logic        sel;

    logic        rv1, rdy1, vld1, err1;
    logic        rv4, rdy4, vld4, err4;
    logic [31:0] rd1, rd4;

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem   [2][1024];
    logic [3:0]  m_known [2][1024];

    always #5 clk = ~clk;

    assign rv1       = req_valid & ~sel;
    assign rv4       = req_valid & sel;
    assign cur_ready = sel ? rdy4 : rdy1;
    assign cur_valid = sel ? vld4 : vld1;
    assign cur_err   = sel ? err4 : err1;
    assign cur_rdata = sel ? rd4  : rd1;

    ysyx_24120009_dmem_resp #(.LATENCY(1)) u_dut1 (
        .clk (clk), .rst (rst),
        .req_valid (rv1), .req_ready (rdy1), .req_addr (req_addr), .req_wen (req_wen),
        .req_wdata (req_wdata), .req_wmask (req_wmask),
        .rsp_valid (vld1), .rsp_ready (rsp_ready), .rsp_rdata (rd1), .rsp_err (err1)
    );

    ysyx_24120009_dmem_resp #(.LATENCY(4)) u_dut4 (
        .clk (clk), .rst (rst),
        .req_valid (rv4), .req_ready (rdy4), .req_addr (req_addr), .req_wen (req_wen),
        .req_wdata (req_wdata), .req_wmask (req_wmask),
        .rsp_valid (vld4), .rsp_ready (rsp_ready), .rsp_rdata (rd4), .rsp_err (err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    // One full transaction on the selected instance with cycle-exact latency checks
    task automatic do_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                          input logic [3:0] wmask, input int stall, input string tag);
        int          sid;
        int          lat;
        bit          seen;
        logic [31:0] off;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] cmp_m;
        int unsigned idx;
        sid = sel ? 1 : 0;
        lat = sel ? 4 : 1;
        @(negedge clk);
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_wmask = wmask;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            if (cur_ready === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            chk($sformatf("%s.ready_timeout", tag), 32'(cur_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        off     = addr - BASE;
        exp_err = (off >= 32'h0000_1000);
        idx     = int'(off[11:2]);
        exp_rd  = 32'h0;
        cmp_m   = 32'hFFFF_FFFF;
        if (!exp_err) begin
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) begin
                        m_mem[sid][idx][b*8 +: 8] = wdata[b*8 +: 8];
                        m_known[sid][idx][b]      = 1'b1;
                    end
                end
            end else begin
                exp_rd = m_mem[sid][idx];
                cmp_m  = lane_bits(m_known[sid][idx]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s.early_valid%0d", tag, k), 32'(cur_valid), 32'd0);
            chk($sformatf("%s.busy_ready%0d", tag, k), 32'(cur_ready), 32'd0);
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            chk($sformatf("%s.valid%0d", tag, s), 32'(cur_valid), 32'd1);
            chk($sformatf("%s.err%0d", tag, s), 32'(cur_err), 32'(exp_err));
            chk($sformatf("%s.rdata%0d", tag, s), cur_rdata & cmp_m, exp_rd & cmp_m);
            chk($sformatf("%s.stall_ready%0d", tag, s), 32'(cur_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s.done_valid", tag), 32'(cur_valid), 32'd0);
        chk($sformatf("%s.done_ready", tag), 32'(cur_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
        if (r == 1) return BASE - 32'(4 * $urandom_range(1, 64));
        return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) begin
                m_mem[d][i]   = 32'h0;
                m_known[d][i] = 4'h0;
            end
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wmask = 4'h0; rsp_ready = 1'b0; sel = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst.ready1", 32'(rdy1), 32'd0);
        chk("rst.ready4", 32'(rdy4), 32'd0);
        chk("rst.valid1", 32'(vld1), 32'd0);
        chk("rst.valid4", 32'(vld4), 32'd0);
        chk("rst.rdata1", rd1, 32'h0);
        chk("rst.err1", 32'(err1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.ready1", 32'(rdy1), 32'd1);
        chk("post_rst.ready4", 32'(rdy4), 32'd1);

        // directed, LATENCY=1
        sel = 1'b0;
        do_txn(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, "wr_beef");
        do_txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0, "rd_beef");
        do_txn(BASE + 32'h10, 1'b1, 32'h0000_AA00, 4'b0010, 0, "wr_lane1");
        do_txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0, "rd_lane1");
        chk("lane1_model", m_mem[0][4], 32'hDEAD_AAEF);
        do_txn(BASE, 1'b1, 32'h0BAD_F00D, 4'hF, 0, "wr_w0");
        do_txn(BASE + 32'h1000, 1'b0, 32'h0, 4'h0, 0, "rd_err_hi");
        do_txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, "rd_err_lo");
        do_txn(BASE + 32'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, "wr_err_hi");
        do_txn(BASE, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, "wr_nomask");
        do_txn(BASE, 1'b0, 32'h0, 4'h0, 0, "rd_w0");
        do_txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 5, "rd_stall5");

        // directed, LATENCY=4
        sel = 1'b1;
        do_txn(BASE + 32'h20, 1'b1, 32'hCAFE_0123, 4'hF, 0, "l4_wr");
        do_txn(BASE + 32'h20, 1'b0, 32'h0, 4'h0, 5, "l4_rd_stall");
        do_txn(BASE + 32'h1004, 1'b0, 32'h0, 4'h0, 0, "l4_rd_err");

        // reset while the LATENCY=4 instance is waiting on an accepted write
        @(negedge clk);
        req_addr = BASE + 32'h40; req_wen = 1'b1; req_wdata = 32'h1234_5678;
        req_wmask = 4'hF; req_valid = 1'b1; rsp_ready = 1'b1;
        chk("mid_rst.pre_ready", 32'(cur_ready), 32'd1);
        m_mem[1][16] = 32'h1234_5678;
        m_known[1][16] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst.in_ready", 32'(cur_ready), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("mid_rst.valid%0d", c), 32'(cur_valid), 32'd0);
            chk($sformatf("mid_rst.ready%0d", c), 32'(cur_ready), 32'd1);
        end
        do_txn(BASE + 32'h40, 1'b0, 32'h0, 4'h0, 0, "mid_rst.rd");

        // randomized traffic on both instances against the word model
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            for (int i = 0; i < 16; i++)
                do_txn(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 0, $sformatf("pre%0d_%0d", d, i));
            for (int i = 0; i < ((d == 0) ? 40 : 25); i++)
                do_txn(rand_addr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", d, i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
